// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 3;

    // Operand source selects driven to the EX-stage operand muxes.
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDUSE   = 2'd1,
        ST_MEMWAIT = 2'd2,
        ST_FLUSH   = 2'd3
    } hz_state_e;

    // Youngest writer wins: the MEM-stage result is newer than the WB one.
    function automatic logic [1:0] fwd_select(
        input logic                  mem_we,
        input logic [REG_ADDR_W-1:0] mem_addr,
        input logic                  wb_we,
        input logic [REG_ADDR_W-1:0] wb_addr,
        input logic [REG_ADDR_W-1:0] src_addr
    );
        if (mem_we && (mem_addr == src_addr)) begin
            return FWD_EXMEM;
        end
        if (wb_we && (wb_addr == src_addr)) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// Operand forwarding selects for the rs and rt operands of the ID instruction.
// Latency: purely combinational, same cycle.
// Backpressure: none; selects follow the inputs every cycle.
module pipeline_fwd_unit
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    input  logic                  mem_regwrite,
    input  logic [REG_ADDR_W-1:0] mem_write_addr,
    input  logic                  wb_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_write_addr,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel
);

    // Register 0 is a real register here, so no zero-address exclusion.
    always_comb begin
        fwd_a_sel = fwd_select(mem_regwrite, mem_write_addr, wb_regwrite, wb_write_addr, rs_addr);
        fwd_b_sel = fwd_select(mem_regwrite, mem_write_addr, wb_regwrite, wb_write_addr, rt_addr);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes, memory-wait hold and forwarding selects.
// Latency: hazard outputs are combinational in the detection cycle; stall count lags one cycle.
// Backpressure: dmem_ready_i low freezes the pipe (pipe_hold_o) until the access completes.
// Build option: define HAZARD_FORWARD_EN for MEM/WB forwarding; otherwise every RAW match stalls.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [REG_ADDR_W-1:0] id_rs_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rt_addr_i,
    input  logic                  id_uses_rt_i,
    input  logic                  ex_regwrite_i,
    input  logic                  ex_memread_i,
    input  logic [REG_ADDR_W-1:0] ex_write_addr_i,
    input  logic                  mem_regwrite_i,
    input  logic [REG_ADDR_W-1:0] mem_write_addr_i,
    input  logic                  wb_regwrite_i,
    input  logic [REG_ADDR_W-1:0] wb_write_addr_i,
    input  logic                  mem_access_i,
    input  logic                  dmem_ready_i,
    input  logic                  branch_taken_i,
    output logic                  pc_en_o,
    output logic                  ifid_en_o,
    output logic                  ifid_flush_o,
    output logic                  idex_flush_o,
    output logic                  pipe_hold_o,
    output logic [1:0]            fwd_a_sel_o,
    output logic [1:0]            fwd_b_sel_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    hz_state_e        state_q;
    hz_state_e        cur_state;
    logic [1:0]       raw_a_sel;
    logic [1:0]       raw_b_sel;
    logic             ex_match;
    logic             ld_hazard;
    logic [CNT_W-1:0] cnt_q;

    pipeline_fwd_unit u_fwd (
        .rs_addr        (id_rs_addr_i),
        .rt_addr        (id_rt_addr_i),
        .mem_regwrite   (mem_regwrite_i),
        .mem_write_addr (mem_write_addr_i),
        .wb_regwrite    (wb_regwrite_i),
        .wb_write_addr  (wb_write_addr_i),
        .fwd_a_sel      (raw_a_sel),
        .fwd_b_sel      (raw_b_sel)
    );

    assign ex_match = ex_regwrite_i &&
                      ((ex_write_addr_i == id_rs_addr_i) ||
                       (id_uses_rt_i && (ex_write_addr_i == id_rt_addr_i)));

`ifdef HAZARD_FORWARD_EN
    // With forwarding only a load in EX cannot be bypassed in time.
    assign ld_hazard   = ex_match && ex_memread_i;
    assign fwd_a_sel_o = raw_a_sel;
    assign fwd_b_sel_o = raw_b_sel;
`else
    // Without forwarding any pending writer of a source operand stalls ID;
    // the forwarding unit's selects double as MEM/WB match detectors.
    logic unused_memread;
    assign unused_memread = ex_memread_i;
    assign ld_hazard      = ex_match ||
                            (raw_a_sel != FWD_RF) ||
                            (id_uses_rt_i && (raw_b_sel != FWD_RF));
    assign fwd_a_sel_o    = FWD_RF;
    assign fwd_b_sel_o    = FWD_RF;
`endif

    // State in force this cycle: RUN-side decisions (including MEMWAIT exit) resolve combinationally.
    always_comb begin
        cur_state = ST_RUN;
        if (!rst_ni) begin
            cur_state = ST_RUN;
        end else if (!dmem_ready_i && ((state_q == ST_MEMWAIT) || mem_access_i)) begin
            cur_state = ST_MEMWAIT;
        end else if (branch_taken_i) begin
            cur_state = ST_FLUSH;
        end else if (ld_hazard) begin
            cur_state = ST_LDUSE;
        end
    end

    // Pipeline control decoded from the state in force this cycle.
    always_comb begin
        pc_en_o      = 1'b1;
        ifid_en_o    = 1'b1;
        ifid_flush_o = 1'b0;
        idex_flush_o = 1'b0;
        pipe_hold_o  = 1'b0;
        case (cur_state)
            ST_LDUSE: begin
                pc_en_o      = 1'b0;
                ifid_en_o    = 1'b0;
                idex_flush_o = 1'b1;
            end
            ST_MEMWAIT: begin
                pc_en_o     = 1'b0;
                ifid_en_o   = 1'b0;
                pipe_hold_o = 1'b1;
            end
            ST_FLUSH: begin
                ifid_flush_o = 1'b1;
                idex_flush_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Record last cycle's state; only MEMWAIT carries over, LDUSE/FLUSH re-evaluate from RUN.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= cur_state;
        end
    end

    // Saturating count of stall cycles (load-use bubbles and memory waits).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (((cur_state == ST_LDUSE) || (cur_state == ST_MEMWAIT)) &&
                     (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // {pc_en, ifid_en, ifid_flush, idex_flush, pipe_hold}
    localparam logic [4:0] C_RUN = 5'b11000;
    localparam logic [4:0] C_LDU = 5'b00010;
    localparam logic [4:0] C_MW  = 5'b00001;
    localparam logic [4:0] C_FL  = 5'b11110;

    localparam int K_RUN = 0;
    localparam int K_LDU = 1;
    localparam int K_MW  = 2;
    localparam int K_FL  = 3;

    typedef struct packed {
        logic [2:0] rs;
        logic [2:0] rt;
        logic       urt;
        logic       ex_we;
        logic       ex_rd;
        logic [2:0] ex_a;
        logic       mem_we;
        logic [2:0] mem_a;
        logic       wb_we;
        logic [2:0] wb_a;
        logic       acc;
        logic       rdy;
        logic       br;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [8:0] exp;
        string      name;
    } vec_t;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic [2:0]       id_rs_addr_i, id_rt_addr_i, ex_write_addr_i, mem_write_addr_i, wb_write_addr_i;
    logic             id_uses_rt_i, ex_regwrite_i, ex_memread_i, mem_regwrite_i, wb_regwrite_i;
    logic             mem_access_i, dmem_ready_i, branch_taken_i;
    logic             pc_en_o, ifid_en_o, ifid_flush_o, idex_flush_o, pipe_hold_o;
    logic [1:0]       fwd_a_sel_o, fwd_b_sel_o;
    logic [CNT_W-1:0] stall_cnt_o;

    int checks = 0;
    int errors = 0;
    bit m_wait = 1'b0;
    int m_cnt  = 0;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .id_rs_addr_i     (id_rs_addr_i),
        .id_rt_addr_i     (id_rt_addr_i),
        .id_uses_rt_i     (id_uses_rt_i),
        .ex_regwrite_i    (ex_regwrite_i),
        .ex_memread_i     (ex_memread_i),
        .ex_write_addr_i  (ex_write_addr_i),
        .mem_regwrite_i   (mem_regwrite_i),
        .mem_write_addr_i (mem_write_addr_i),
        .wb_regwrite_i    (wb_regwrite_i),
        .wb_write_addr_i  (wb_write_addr_i),
        .mem_access_i     (mem_access_i),
        .dmem_ready_i     (dmem_ready_i),
        .branch_taken_i   (branch_taken_i),
        .pc_en_o          (pc_en_o),
        .ifid_en_o        (ifid_en_o),
        .ifid_flush_o     (ifid_flush_o),
        .idex_flush_o     (idex_flush_o),
        .pipe_hold_o      (pipe_hold_o),
        .fwd_a_sel_o      (fwd_a_sel_o),
        .fwd_b_sel_o      (fwd_b_sel_o),
        .stall_cnt_o      (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic stim_t mk(input int rs, input int rt, input bit urt,
                                 input bit ex_we, input bit ex_rd, input int ex_a,
                                 input bit mem_we, input int mem_a,
                                 input bit wb_we, input int wb_a,
                                 input bit acc, input bit rdy, input bit br);
        stim_t s;
        s.rs = 3'(rs);   s.rt = 3'(rt);   s.urt = urt;
        s.ex_we = ex_we; s.ex_rd = ex_rd; s.ex_a = 3'(ex_a);
        s.mem_we = mem_we; s.mem_a = 3'(mem_a);
        s.wb_we = wb_we; s.wb_a = 3'(wb_a);
        s.acc = acc; s.rdy = rdy; s.br = br;
        return s;
    endfunction

    // Reference model: what kind of cycle the rules call for.
    function automatic int m_kind(input stim_t s, input bit waiting);
        bit ex_hit  = s.ex_we  && (s.ex_a  == s.rs || (s.urt && s.ex_a  == s.rt));
        bit mem_hit = s.mem_we && (s.mem_a == s.rs || (s.urt && s.mem_a == s.rt));
        bit wb_hit  = s.wb_we  && (s.wb_a  == s.rs || (s.urt && s.wb_a  == s.rt));
        bit hazard  = FWD ? (ex_hit && s.ex_rd) : (ex_hit || mem_hit || wb_hit);
        if (!s.rdy && (waiting || s.acc)) return K_MW;
        if (s.br) return K_FL;
        if (hazard) return K_LDU;
        return K_RUN;
    endfunction

    function automatic logic [1:0] m_fwd(input stim_t s, input logic [2:0] r);
        if (!FWD) return 2'b00;
        if (s.mem_we && s.mem_a == r) return 2'b01;
        if (s.wb_we && s.wb_a == r) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [8:0] m_out(input stim_t s, input bit waiting);
        logic [4:0] c;
        case (m_kind(s, waiting))
            K_LDU:   c = C_LDU;
            K_MW:    c = C_MW;
            K_FL:    c = C_FL;
            default: c = C_RUN;
        endcase
        return {c, m_fwd(s, s.rs), m_fwd(s, s.rt)};
    endfunction

    task automatic m_advance(input stim_t s);
        int k;
        k = m_kind(s, m_wait);
        if ((k == K_LDU || k == K_MW) && m_cnt < CNT_MAX) m_cnt++;
        m_wait = (k == K_MW);
    endtask

    task automatic drive(input stim_t s);
        id_rs_addr_i = s.rs;      id_rt_addr_i = s.rt;       id_uses_rt_i = s.urt;
        ex_regwrite_i = s.ex_we;  ex_memread_i = s.ex_rd;    ex_write_addr_i = s.ex_a;
        mem_regwrite_i = s.mem_we; mem_write_addr_i = s.mem_a;
        wb_regwrite_i = s.wb_we;  wb_write_addr_i = s.wb_a;
        mem_access_i = s.acc;     dmem_ready_i = s.rdy;      branch_taken_i = s.br;
    endtask

    task automatic check(input string name, input logic [8:0] exp_out, input int exp_cnt);
        logic [8:0] act;
        act = {pc_en_o, ifid_en_o, ifid_flush_o, idex_flush_o, pipe_hold_o, fwd_a_sel_o, fwd_b_sel_o};
        checks++;
        if (act !== exp_out || stall_cnt_o !== CNT_W'(exp_cnt)) begin
            errors++;
            $display("FAIL %s: got ctl/fwd=%b cnt=%0d, expected ctl/fwd=%b cnt=%0d",
                     name, act, stall_cnt_o, exp_out, exp_cnt);
        end
    endtask

    task automatic apply_check(input stim_t s, input string name, input logic [8:0] exp_out, input int exp_cnt);
        @(negedge clk_i);
        drive(s);
        #2;
        check(name, exp_out, exp_cnt);
        m_advance(s);
    endtask

    task automatic do_reset(input stim_t idle);
        @(negedge clk_i);
        drive(idle);
        rst_ni = 1'b0;
        #2;
        check("reset_state", {C_RUN, 4'b0000}, 0);
        m_wait = 1'b0;
        m_cnt  = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        vec_t  tbl[17];
        stim_t idle, ldu, mwait, s;

        idle  = mk(0,0,0, 0,0,0, 0,0, 0,0, 0,1,0);
        ldu   = mk(3,4,1, 1,1,3, 0,0, 0,0, 0,1,0);
        mwait = mk(1,2,1, 0,0,0, 0,0, 0,0, 1,0,0);

        tbl[0]  = '{mk(1,2,1, 0,0,0, 0,0, 0,0, 0,1,0), {C_RUN, 4'b0000}, "run_idle"};
        tbl[1]  = '{mk(3,4,1, 1,1,3, 0,0, 0,0, 0,1,0), {C_LDU, 4'b0000}, "ldu_rs"};
        tbl[2]  = '{mk(3,4,0, 1,1,4, 0,0, 0,0, 0,1,0), {C_RUN, 4'b0000}, "ldu_rt_not_read"};
        tbl[3]  = '{mk(3,4,1, 1,1,4, 0,0, 0,0, 0,1,0), {C_LDU, 4'b0000}, "ldu_rt"};
        tbl[4]  = '{mk(0,7,0, 1,1,0, 0,0, 0,0, 0,1,0), {C_LDU, 4'b0000}, "ldu_r0"};
        tbl[5]  = '{mk(3,4,1, 0,1,3, 0,0, 0,0, 0,1,0), {C_RUN, 4'b0000}, "load_no_regwrite"};
        tbl[6]  = '{mk(2,4,1, 1,0,2, 0,0, 0,0, 0,1,0), FWD ? {C_RUN, 4'b0000} : {C_LDU, 4'b0000}, "ex_alu_raw"};
        tbl[7]  = '{mk(5,1,1, 0,0,0, 1,5, 1,5, 0,1,0), FWD ? {C_RUN, 4'b0100} : {C_LDU, 4'b0000}, "fwd_mem_wins"};
        tbl[8]  = '{mk(5,1,1, 0,0,0, 0,5, 1,5, 0,1,0), FWD ? {C_RUN, 4'b1000} : {C_LDU, 4'b0000}, "fwd_wb_only"};
        tbl[9]  = '{mk(1,6,1, 0,0,0, 1,6, 0,0, 0,1,0), FWD ? {C_RUN, 4'b0001} : {C_LDU, 4'b0000}, "fwd_b_mem"};
        tbl[10] = '{mk(1,6,0, 0,0,0, 1,6, 0,0, 0,1,0), FWD ? {C_RUN, 4'b0001} : {C_RUN, 4'b0000}, "fwd_b_rt_unread"};
        tbl[11] = '{mk(2,3,1, 0,0,0, 1,3, 1,2, 0,1,0), FWD ? {C_RUN, 4'b1001} : {C_LDU, 4'b0000}, "fwd_a_wb_b_mem"};
        tbl[12] = '{mk(1,2,1, 0,0,0, 0,0, 0,0, 0,1,1), {C_FL,  4'b0000}, "branch"};
        tbl[13] = '{mk(3,4,1, 1,1,3, 0,0, 0,0, 0,1,1), {C_FL,  4'b0000}, "branch_over_ldu"};
        tbl[14] = '{mk(3,4,1, 1,1,3, 0,0, 0,0, 1,0,1), {C_MW,  4'b0000}, "memwait_over_all"};
        tbl[15] = '{mk(1,2,1, 0,0,0, 0,0, 0,0, 1,1,0), {C_RUN, 4'b0000}, "mem_ready_now"};
        tbl[16] = '{mk(1,2,1, 0,0,0, 0,0, 0,0, 0,0,0), {C_RUN, 4'b0000}, "no_access_not_ready"};

        drive(idle);
        #3;
        check("por_state", {C_RUN, 4'b0000}, 0);
        do_reset(idle);

        foreach (tbl[i]) begin
            apply_check(tbl[i].s, tbl[i].name, tbl[i].exp, m_cnt);
            apply_check(idle, "idle_after_vec", m_out(idle, m_wait), m_cnt);
        end

        // Single load-use bubble then back to RUN with one stall counted.
        do_reset(idle);
        apply_check(ldu,  "lu_bubble", {C_LDU, 4'b0000}, 0);
        apply_check(idle, "lu_then_run", {C_RUN, 4'b0000}, 1);

        // Three not-ready cycles hold the pipe, the ready cycle runs.
        do_reset(idle);
        for (int i = 0; i < 3; i++) apply_check(mwait, "mw_hold", {C_MW, 4'b0000}, i);
        apply_check(mk(1,2,1, 0,0,0, 0,0, 0,0, 1,1,0), "mw_exit", {C_RUN, 4'b0000}, 3);
        apply_check(idle, "mw_after", {C_RUN, 4'b0000}, 3);

        // Waiting persists with mem_access dropped; ready plus branch flushes.
        do_reset(idle);
        apply_check(mwait, "mw_enter", {C_MW, 4'b0000}, 0);
        apply_check(mk(1,2,1, 0,0,0, 0,0, 0,0, 0,0,0), "mw_stay_noacc", {C_MW, 4'b0000}, 1);
        apply_check(mk(1,2,1, 0,0,0, 0,0, 0,0, 0,1,1), "mw_exit_flush", {C_FL, 4'b0000}, 2);
        apply_check(idle, "flush_one_cycle", {C_RUN, 4'b0000}, 2);

        // Branch with a load-use: one flush, no bubble counted.
        do_reset(idle);
        apply_check(mk(3,4,1, 1,1,3, 0,0, 0,0, 0,1,1), "br_ldu_flush", {C_FL, 4'b0000}, 0);
        apply_check(idle, "br_ldu_after", {C_RUN, 4'b0000}, 0);

        // Asynchronous reset in the middle of a memory wait.
        do_reset(idle);
        for (int i = 0; i < 3; i++) apply_check(mwait, "pre_rst_mw", {C_MW, 4'b0000}, i);
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        check("async_rst_mw", {C_RUN, 4'b0000}, 0);
        m_wait = 1'b0;
        m_cnt  = 0;
        drive(idle);
        @(negedge clk_i);
        rst_ni = 1'b1;
        apply_check(idle, "no_residual", {C_RUN, 4'b0000}, 0);

        // Counter saturation.
        do_reset(idle);
        for (int i = 0; i < 300; i++) apply_check(ldu, "sat_ldu", {C_LDU, 4'b0000}, (i > CNT_MAX) ? CNT_MAX : i);
        apply_check(idle, "sat_final", {C_RUN, 4'b0000}, CNT_MAX);

        // Randomized traffic against the model.
        do_reset(idle);
        for (int i = 0; i < 3000; i++) begin
            s.rs = 3'($urandom_range(0, 7));  s.rt = 3'($urandom_range(0, 7));
            s.urt = 1'($urandom_range(0, 1));
            s.ex_we = 1'($urandom_range(0, 1)); s.ex_rd = 1'($urandom_range(0, 1));
            s.ex_a = 3'($urandom_range(0, 7));
            s.mem_we = 1'($urandom_range(0, 1)); s.mem_a = 3'($urandom_range(0, 7));
            s.wb_we = 1'($urandom_range(0, 1));  s.wb_a = 3'($urandom_range(0, 7));
            s.acc = ($urandom_range(0, 9) < 3);
            s.rdy = ($urandom_range(0, 9) < 6);
            s.br  = ($urandom_range(0, 9) == 0);
            apply_check(s, "random", m_out(s, m_wait), m_cnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
